// File: rtl/polyphonic_tone_mixer.sv
// Multi-voice tone generator: per-voice phase accumulators, shared waveform shaper, mixed offset-binary sample
// handed to the DAC controller. Define TONE_MIXER_DEBUG_EN to add the debugString status port.
module polyphonic_tone_mixer #(
   parameter int NUM_VOICES        = 6,
   parameter int SAMPLE_BITS       = 12,
   parameter int PHASE_BITS        = 24,
   parameter int CLOCKS_PER_SAMPLE = 1136
) (
   input  logic                             clock_50Mhz,
   input  logic                             reset_n,
   input  logic                             enable,
   input  logic [NUM_VOICES-1:0]            voiceActive,
   input  logic [NUM_VOICES*PHASE_BITS-1:0] voicePhaseStep,
   input  logic [1:0]                       waveMode,
   input  logic                             dacBusy,
   output logic [SAMPLE_BITS-1:0]           outputSample,
   output logic                             sendSample_n,
   output logic [4:0]                       activeVoiceCount,
   output logic [7:0]                       droppedCount
`ifdef TONE_MIXER_DEBUG_EN
   ,
   output logic [31:0]                      debugString
`endif
);

   localparam int SHIFT  = $clog2(NUM_VOICES);
   localparam int ACC_W  = SAMPLE_BITS + SHIFT + 1;
   localparam int TICK_W = $clog2(CLOCKS_PER_SAMPLE + 1);
   localparam int IDX_W  = 4;

   localparam logic [TICK_W-1:0]           TICK_LAST = TICK_W'(CLOCKS_PER_SAMPLE - 1);
   localparam logic [IDX_W-1:0]            IDX_LAST  = IDX_W'(NUM_VOICES - 1);
   localparam logic [SAMPLE_BITS-1:0]      MIDPOINT  = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]     MID_ACC   = {{(ACC_W-SAMPLE_BITS){1'b0}}, MIDPOINT};
   localparam logic signed [SAMPLE_BITS:0] WAVE_MAX  = {2'b00, {(SAMPLE_BITS-1){1'b1}}};
   localparam logic signed [SAMPLE_BITS:0] WAVE_MIN  = {2'b11, {(SAMPLE_BITS-1){1'b0}}};
   localparam logic signed [SAMPLE_BITS:0] WAVE_MID  = {2'b01, {(SAMPLE_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCALE = 2'd2,
      ISSUE = 2'd3
   } state_t;

   state_t                         state, next_state;
   logic [TICK_W-1:0]              tick_count;
   logic                           tick;
   logic [IDX_W-1:0]               voice_idx;
   logic signed [ACC_W-1:0]        acc;
   logic signed [ACC_W-1:0]        acc_scaled;
   logic [PHASE_BITS-1:0]          phase [NUM_VOICES];
   logic [SAMPLE_BITS-1:0]         cur_p;
   logic                           cur_active;
   logic signed [SAMPLE_BITS:0]    cur_wave;
   logic [4:0]                     voice_popcount;

   // Shaper output is one bit wider than the sample so every waveform stays exact as a signed value.
   function automatic logic signed [SAMPLE_BITS:0] wave_value(input logic [1:0] mode,
                                                              input logic [SAMPLE_BITS-1:0] p);
      logic signed [SAMPLE_BITS:0] p_ext;
      logic signed [SAMPLE_BITS:0] q_ext;
      p_ext = signed'({1'b0, p});
      q_ext = signed'({1'b0, p[SAMPLE_BITS-2:0], 1'b0});
      case (mode)
         2'd0:    return p[SAMPLE_BITS-1] ? WAVE_MIN : WAVE_MAX;
         2'd1:    return p_ext - WAVE_MID;
         2'd2:    return p[SAMPLE_BITS-1] ? (WAVE_MAX - q_ext) : (q_ext - WAVE_MID);
         default: return '0;
      endcase
   endfunction

   assign tick = enable && (tick_count == TICK_LAST);

   // NOTE: every variable gets a default before the case/loop so no path leaves it unassigned (no latch).
   always_comb begin
      cur_p      = '0;
      cur_active = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (voice_idx == IDX_W'(v)) begin
            cur_p      = phase[v][PHASE_BITS-1 -: SAMPLE_BITS];
            cur_active = voiceActive[v];
         end
      end
   end

   assign cur_wave   = cur_active ? wave_value(waveMode, cur_p) : '0;
   assign acc_scaled = acc >>> SHIFT;

   always_comb begin
      voice_popcount = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         voice_popcount = voice_popcount + 5'(voiceActive[v]);
      end
   end

   always_comb begin
      next_state   = state;
      sendSample_n = 1'b1;
      if (!enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (tick) next_state = ACCUM;
            ACCUM:   if (voice_idx == IDX_LAST) next_state = SCALE;
            SCALE:   next_state = ISSUE;
            ISSUE: begin
               if (!dacBusy) begin
                  sendSample_n = 1'b0;
                  next_state   = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         tick_count <= '0;
      end else if (!enable || tick) begin
         tick_count <= '0;
      end else begin
         tick_count <= tick_count + TICK_W'(1);
      end
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         voice_idx        <= '0;
         acc              <= '0;
         outputSample     <= MIDPOINT;
         activeVoiceCount <= '0;
         droppedCount     <= '0;
      end else begin
         activeVoiceCount <= voice_popcount;
         if (tick && state != IDLE && droppedCount != 8'hFF) begin
            droppedCount <= droppedCount + 8'd1;
         end
         if (!enable) begin
            voice_idx    <= '0;
            acc          <= '0;
            outputSample <= MIDPOINT;
         end else begin
            case (state)
               IDLE: begin
                  if (tick) begin
                     acc       <= '0;
                     voice_idx <= '0;
                  end
               end
               ACCUM: begin
                  acc       <= acc + ACC_W'(cur_wave);
                  voice_idx <= voice_idx + IDX_W'(1);
               end
               SCALE:   outputSample <= SAMPLE_BITS'(acc_scaled + MID_ACC);
               default: ;
            endcase
         end
      end
   end

   // NOTE: phases live in flops, not RAM, because they must read as zero straight out of reset.
   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
      end else if (!enable) begin
         for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
      end else if (state == ACCUM) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_idx == IDX_W'(v)) begin
               phase[v] <= voiceActive[v] ? phase[v] + voicePhaseStep[v*PHASE_BITS +: PHASE_BITS] : '0;
            end
         end
      end
   end

`ifdef TONE_MIXER_DEBUG_EN
   assign debugString = {droppedCount, 2'b00, state, voice_idx, 16'(outputSample)};
`endif

endmodule

// File: tb/tb_polyphonic_tone_mixer.sv
// Scoreboard bench for polyphonic_tone_mixer: a sample-level model predicts each strobe's value and cycle,
// a monitor matches them against the DUT's send strobes.
module tb_polyphonic_tone_mixer;

   localparam int NV    = 6;
   localparam int SB    = 12;
   localparam int PB    = 24;
   localparam int CPS   = 1136;
   localparam int MID   = 2048;
   localparam int SHIFT = 3;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              enable = 1'b0;
   logic [NV-1:0]     voiceActive = '0;
   logic [NV*PB-1:0]  voicePhaseStep = '0;
   logic [1:0]        waveMode = 2'd0;
   logic              dacBusy = 1'b0;
   logic [SB-1:0]     outputSample;
   logic              sendSample_n;
   logic [4:0]        activeVoiceCount;
   logic [7:0]        droppedCount;

   polyphonic_tone_mixer #(
      .NUM_VOICES(NV), .SAMPLE_BITS(SB), .PHASE_BITS(PB), .CLOCKS_PER_SAMPLE(CPS)
   ) dut (
      .clock_50Mhz(clk),
      .reset_n(reset_n),
      .enable(enable),
      .voiceActive(voiceActive),
      .voicePhaseStep(voicePhaseStep),
      .waveMode(waveMode),
      .dacBusy(dacBusy),
      .outputSample(outputSample),
      .sendSample_n(sendSample_n),
      .activeVoiceCount(activeVoiceCount),
      .droppedCount(droppedCount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   typedef struct {
      int sample;
      int at;
   } exp_t;

   exp_t        exp_q[$];
   int          run_len = 0;
   bit          m_busy = 1'b0;
   int          m_ready = 0;
   int          m_sample = MID;
   int          m_dropped = 0;
   int unsigned m_phase[NV];

   function automatic int wave_of(input int mode, input int unsigned ph);
      int p;
      int q;
      p = int'(ph >> (PB - SB));
      q = (p % MID) * 2;
      case (mode)
         0:       return (p < MID) ? MID - 1 : -MID;
         1:       return p - MID;
         2:       return (p < MID) ? q - MID : (MID - 1) - q;
         default: return 0;
      endcase
   endfunction

   // Reference model: one evaluation per clock cycle, looking at inputs as the DUT sees them at the next edge.
   initial begin : model
      bit          tick;
      int          sum;
      int unsigned stp;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            run_len   = 0;
            m_busy    = 1'b0;
            m_dropped = 0;
            exp_q.delete();
            foreach (m_phase[v]) m_phase[v] = 0;
         end else if (!enable) begin
            run_len = 0;
            m_busy  = 1'b0;
            foreach (m_phase[v]) m_phase[v] = 0;
         end else begin
            tick = ((run_len % CPS) == CPS - 1);
            run_len++;
            if (tick) begin
               if (m_busy) begin
                  if (m_dropped < 255) m_dropped++;
               end else begin
                  sum = 0;
                  for (int v = 0; v < NV; v++) begin
                     if (voiceActive[v]) begin
                        stp = int'(voicePhaseStep[v*PB +: PB]);
                        sum += wave_of(int'(waveMode), m_phase[v]);
                        m_phase[v] = (m_phase[v] + stp) & 32'h00FF_FFFF;
                     end else begin
                        m_phase[v] = 0;
                     end
                  end
                  m_sample = MID + (sum >>> SHIFT);
                  m_busy   = 1'b1;
                  m_ready  = cyc + NV + 2;
               end
            end
            if (m_busy && cyc >= m_ready && !dacBusy) begin
               exp_q.push_back('{sample: m_sample, at: cyc});
               m_busy = 1'b0;
            end
         end
      end
   end

   int strobe_cnt  = 0;
   int last_sample = 0;
   int last_at     = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (reset_n && sendSample_n === 1'b0) begin
            strobe_cnt++;
            last_sample = int'(outputSample);
            last_at     = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: strobe at cycle %0d sample %0d, required no strobe", cyc, outputSample);
            end else begin
               e = exp_q.pop_front();
               check("sample_value", int'(outputSample), e.sample);
               check("strobe_cycle", cyc, e.at);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_until(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic wait_strobe(output int sample, output int at);
      int n0;
      n0 = strobe_cnt;
      for (int i = 0; i < 6000; i++) begin
         step(1);
         if (strobe_cnt != n0) begin
            sample = last_sample;
            at     = last_at;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL strobe_timeout: got no strobe in 6000 cycles, required one");
      sample = -1;
      at     = -1;
   endtask

   task automatic set_step(input int v, input logic [PB-1:0] val);
      voicePhaseStep[v*PB +: PB] = val;
   endtask

   initial begin : watchdog
      #(150000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int s;
      int at;
      int e;
      int prev;
      int n0;
      int sq_exp[4];
      sq_exp = '{2303, 1792, 2303, 1792};

      #1 reset_n = 1'b0;
      step(3);
      check("reset_sample", int'(outputSample), MID);
      check("reset_send_n", int'(sendSample_n), 1);
      check("reset_active_count", int'(activeVoiceCount), 0);
      check("reset_dropped", int'(droppedCount), 0);
      reset_n = 1'b1;
      step(2);

      // Silence: midpoint samples, fixed latency and period.
      enable = 1'b1;
      e = cyc;
      wait_strobe(s, at);
      check("idle_sample", s, MID);
      check("first_latency", at - e, CPS - 1 + NV + 2);
      prev = at;
      wait_strobe(s, at);
      check("idle_sample_2", s, MID);
      check("tick_period", at - prev, CPS);

      // Single square voice at half-cycle step.
      voiceActive = 6'b000001;
      waveMode    = 2'd0;
      set_step(0, 24'h80_0000);
      step(1);
      check("active_count_1", int'(activeVoiceCount), $countones(voiceActive));
      for (int i = 0; i < 4; i++) begin
         wait_strobe(s, at);
         check("square_one_voice", s, sq_exp[i]);
      end

      // All voices square from zero phase.
      enable = 1'b0;
      step(1);
      voiceActive = 6'b111111;
      for (int v = 0; v < NV; v++) set_step(v, 24'h80_0000);
      enable = 1'b1;
      wait_strobe(s, at);
      check("square_all_voices", s, 3583);
      check("active_count_6", int'(activeVoiceCount), 6);

      // Saw voice with DAC busy across two further ticks.
      enable = 1'b0;
      step(1);
      voiceActive = 6'b000001;
      waveMode    = 2'd1;
      set_step(0, 24'h10_0000);
      dacBusy = 1'b1;
      enable  = 1'b1;
      e = cyc;
      step_until(e + CPS - 1 + 2300);
      dacBusy = 1'b0;
      wait_strobe(s, at);
      check("saw_after_busy", s, 1792);
      check("busy_release_cycle", at - e, CPS - 1 + 2300);
      check("dropped_after_busy", int'(droppedCount), 2);
      wait_strobe(s, at);
      check("saw_resumed", s, 1824);
      check("resumed_cycle", at - e, 4 * CPS - 1 + NV + 2);

      // Disable in the middle of voice accumulation.
      enable = 1'b0;
      step(1);
      enable = 1'b1;
      e = cyc;
      wait_strobe(s, at);
      check("saw_restart", s, 1792);
      step_until(e + 2 * CPS - 1 + 3);
      enable = 1'b0;
      step(2);
      check("disable_midpoint", int'(outputSample), MID);
      step(20);
      check("disable_dropped_held", int'(droppedCount), 2);
      enable = 1'b1;
      e = cyc;
      wait_strobe(s, at);
      check("reenable_sample", s, 1792);
      check("reenable_latency", at - e, CPS - 1 + NV + 2);

      // Randomised voices, waveforms, steps and DAC back-pressure.
      for (int it = 0; it < 8; it++) begin
         voiceActive = NV'($urandom);
         waveMode    = 2'($urandom_range(0, 3));
         for (int v = 0; v < NV; v++) set_step(v, PB'($urandom));
         step(1);
         check("active_count_rand", int'(activeVoiceCount), $countones(voiceActive));
         if ($urandom_range(0, 2) == 0) begin
            dacBusy = 1'b1;
            step($urandom_range(1, 2000));
            dacBusy = 1'b0;
         end
         wait_strobe(s, at);
      end
      check("dropped_total", int'(droppedCount), m_dropped);

      // Reset while running.
      step($urandom_range(1, CPS - 1));
      reset_n = 1'b0;
      #1;
      check("midrun_reset_sample", int'(outputSample), MID);
      check("midrun_reset_send_n", int'(sendSample_n), 1);
      check("midrun_reset_dropped", int'(droppedCount), 0);
      check("midrun_reset_count", int'(activeVoiceCount), 0);
      enable = 1'b0;
      step(2);
      reset_n = 1'b1;
      n0 = strobe_cnt;
      step(CPS + 64);
      check("quiet_after_reset", strobe_cnt - n0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
